mem_operand_fetch: RTL and testbench

- Pipeline stage directly upstream of the operand decode mux.
- Registers each instruction from the fetch/decode latch and passes it on.
- For memory-operand instructions, runs a request/acknowledge read on the data-memory port and stalls the front end until data returns.
- Drives the memory operand data, S_OD qualifier and valid/instruction bus consumed by operand decode.

---
 rtl/mem_operand_fetch.sv | 168 ++++++++++++++++
 tb/tb_mem_operand_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_operand_fetch.sv
// Operand-fetch stage: registers each instruction for operand decode and runs a
// req/ack data-memory read for memory-operand instructions, holding the front end.
module mem_operand_fetch #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    input  logic              in_need_mem,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              stall_in,
    input  logic              flush,
    output logic              stall_up,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [15:0]       out_instr,
    output logic [DATA_W-1:0] mem_opdata,
    output logic              s_od,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, HOLD, DRAIN} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         out_instr_q, out_instr_d;
    logic [15:0]         instr_lat_q, instr_lat_d;
    logic [DATA_W-1:0]   mem_opdata_q, mem_opdata_d;
    logic                s_od_q, s_od_d;
    logic                timeout_err_q, timeout_err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                cnt_last;

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        instr_lat_d   = instr_lat_q;
        mem_opdata_d  = mem_opdata_q;
        s_od_d        = s_od_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        cnt_last      = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (flush) begin
                    out_valid_d = 1'b0;
                    s_od_d      = 1'b0;
                end else if (!stall_in) begin
                    if (in_valid && in_need_mem) begin
                        instr_lat_d = in_instr;
                        mem_addr_d  = in_addr;
                        mem_req_d   = 1'b1;
                        out_valid_d = 1'b0;
                        s_od_d      = 1'b0;
                        cnt_d       = 8'd0;
                        state_d     = WAIT_ACK;
                    end else if (in_valid) begin
                        out_valid_d = 1'b1;
                        out_instr_d = in_instr;
                        s_od_d      = 1'b0;
                    end else begin
                        out_valid_d = 1'b0;
                        s_od_d      = 1'b0;
                    end
                end
            end

            WAIT_ACK: begin
                // Ack takes priority over the timeout on the last allowed cycle.
                if (mem_ack || cnt_last) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!mem_ack) timeout_err_d = 1'b1;
                    if (flush) begin
                        out_valid_d = 1'b0;
                        s_od_d      = 1'b0;
                    end else begin
                        out_valid_d  = 1'b1;
                        s_od_d       = 1'b1;
                        out_instr_d  = instr_lat_q;
                        mem_opdata_d = mem_ack ? mem_rdata : '0;
                        if (mem_ack && stall_in) state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (flush) begin
                        out_valid_d = 1'b0;
                        s_od_d      = 1'b0;
                        state_d     = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Squashed access: the bus cycle completes but its data is dropped.
                if (mem_ack || cnt_last) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!mem_ack) timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            HOLD: begin
                if (flush) begin
                    out_valid_d = 1'b0;
                    s_od_d      = 1'b0;
                    state_d     = IDLE;
                end else if (!stall_in) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            instr_lat_q   <= '0;
            mem_opdata_q  <= '0;
            s_od_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            instr_lat_q   <= instr_lat_d;
            mem_opdata_q  <= mem_opdata_d;
            s_od_q        <= s_od_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign stall_up    = (state_q != IDLE) || stall_in;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign mem_opdata  = mem_opdata_q;
    assign s_od        = s_od_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_operand_fetch.sv
// Directed bench for mem_operand_fetch: ALU pass-through, loads, timeout, flush,
// downstream stall and asynchronous reset, with hand-computed expectations.
module tb_mem_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_need_mem;
    logic [15:0] in_addr;
    logic        stall_in;
    logic        flush;
    logic        stall_up;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] mem_opdata;
    logic        s_od;
    logic        timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_operand_fetch #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_need_mem(in_need_mem), .in_addr(in_addr),
        .stall_in(stall_in), .flush(flush), .stall_up(stall_up),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .mem_opdata(mem_opdata),
        .s_od(s_od), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins, input logic need, input logic [15:0] addr);
        in_valid    = 1'b1;
        in_instr    = ins;
        in_need_mem = need;
        in_addr     = addr;
    endtask

    task automatic idle_in();
        in_valid    = 1'b0;
        in_need_mem = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; in_instr = 0; in_need_mem = 0; in_addr = 0;
        stall_in = 0; flush = 0; mem_ack = 0; mem_rdata = 0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s_od", s_od, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_mem_opdata", mem_opdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall_up", stall_up, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ALU op, latency 1
        issue(16'h1230, 1'b0, 16'h0000);
        tick();
        idle_in();
        chk("alu_valid", out_valid, 1);
        chk("alu_instr", out_instr, 16'h1230);
        chk("alu_s_od", s_od, 0);
        chk("alu_no_req", mem_req, 0);
        tick();
        chk("alu_bubble", out_valid, 0);

        // Memory load, ack in 3rd WAIT_ACK cycle
        issue(16'hA001, 1'b1, 16'h0040);
        tick();
        idle_in();
        chk("ld_req0", mem_req, 1);
        chk("ld_addr", mem_addr, 16'h0040);
        chk("ld_stall0", stall_up, 1);
        chk("ld_nvalid", out_valid, 0);
        tick();
        chk("ld_req1", mem_req, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        chk("ld_req2", mem_req, 1);
        chk("ld_stall2", stall_up, 1);
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        chk("ld_req_drop", mem_req, 0);
        chk("ld_data", mem_opdata, 16'hBEEF);
        chk("ld_s_od", s_od, 1);
        chk("ld_valid", out_valid, 1);
        chk("ld_instr", out_instr, 16'hA001);
        chk("ld_stall_rel", stall_up, 0);
        tick();
        chk("ld_bubble", out_valid, 0);

        // Timeout after 4 cycles without ack
        issue(16'hA002, 1'b1, 16'h0080);
        tick();
        idle_in();
        tick(); tick(); tick();
        chk("to_req_last", mem_req, 1);
        chk("to_err_before", timeout_err, 0);
        tick();
        chk("to_req_drop", mem_req, 0);
        chk("to_err", timeout_err, 1);
        chk("to_valid", out_valid, 1);
        chk("to_s_od", s_od, 1);
        chk("to_data", mem_opdata, 0);
        chk("to_instr", out_instr, 16'hA002);
        issue(16'h5555, 1'b0, 16'h0000);
        tick();
        idle_in();
        chk("to_alu_instr", out_instr, 16'h5555);
        chk("to_alu_s_od", s_od, 0);
        chk("to_err_sticky", timeout_err, 1);
        tick();

        // Flush in 2nd WAIT_ACK cycle; ack on the last allowed count
        issue(16'hA003, 1'b1, 16'h00C0);
        tick();
        idle_in();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_req_held", mem_req, 1);
        chk("fl_nvalid", out_valid, 0);
        chk("fl_stall", stall_up, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        chk("fl_req_held2", mem_req, 1);
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        chk("fl_req_drop", mem_req, 0);
        chk("fl_nvalid2", out_valid, 0);
        chk("fl_data_kept", mem_opdata, 0);
        chk("fl_s_od", s_od, 0);
        chk("fl_idle", stall_up, 0);
        tick();

        // Ack arrives under a 3-cycle downstream stall
        issue(16'hA004, 1'b1, 16'h0100);
        tick();
        idle_in();
        tick();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; stall_in = 1'b1;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
        issue(16'h7777, 1'b0, 16'h0000);
        chk("st_valid", out_valid, 1);
        chk("st_data", mem_opdata, 16'hBEEF);
        chk("st_s_od", s_od, 1);
        chk("st_req", mem_req, 0);
        chk("st_stall", stall_up, 1);
        tick();
        chk("st_frozen1", out_instr, 16'hA004);
        tick();
        stall_in = 1'b0;
        chk("st_frozen2", out_instr, 16'hA004);
        chk("st_hold_stall", stall_up, 1);
        tick();
        chk("st_exit_frozen", out_instr, 16'hA004);
        chk("st_exit_data", mem_opdata, 16'hBEEF);
        chk("st_released", stall_up, 0);
        tick();
        chk("st_next_instr", out_instr, 16'h7777);
        chk("st_next_s_od", s_od, 0);

        // Flush overrides a same-cycle IDLE capture
        issue(16'h8888, 1'b0, 16'h0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        chk("fi_nvalid", out_valid, 0);
        chk("fi_instr_kept", out_instr, 16'h7777);

        // Async reset in the middle of WAIT_ACK
        issue(16'hA005, 1'b1, 16'h0200);
        tick();
        idle_in();
        chk("ar_req_pre", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_err", timeout_err, 0);
        chk("ar_stall", stall_up, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
